// File: rtl/bv_cfg_pkg.sv
// bv_cfg_pkg: shared definitions for the bit-vector TCAM configuration loader.
//   - default geometry constants (overridable through the top's parameters)
//   - header field bit positions
//   - sticky error codes
//   - loader FSM state encoding
package bv_cfg_pkg;

  localparam int DEF_SRAM_NUM   = 32;
  localparam int DEF_DATA_DEPTH = 48;
  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_CNT_WIDTH  = 11;

  // Header word layout
  localparam int HDR_SRAM_LSB = 0;
  localparam int HDR_SRAM_MSB = 4;
  localparam int HDR_ADDR_LSB = 5;
  localparam int HDR_ADDR_MSB = 10;
  localparam int HDR_CNT_LSB  = 11;  // field holds count-1
  localparam int HDR_CNT_MSB  = 21;
  localparam int HDR_PAR_BIT  = 31;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_HDR  = 2'd1;
  localparam logic [1:0] ERR_LEN  = 2'd2;
  localparam logic [1:0] ERR_PAR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/bv_cfg_addr_gen.sv
// bv_cfg_addr_gen: SRAM select / address counter with rollover plus a
// remaining-word down-counter.
//   clk, rst      clock, asynchronous active-high reset
//   load_i        load start position and word count
//   inc_i         advance one word (ignored when load_i is high)
//   load_sel_i    start SRAM index
//   load_addr_i   start address inside that SRAM
//   load_cnt_i    number of words in the burst
//   sel_o         current SRAM index
//   addr_o        current address
//   remaining_o   words still to be written
module bv_cfg_addr_gen #(
  parameter int SEL_W  = 5,
  parameter int ADDR_W = 6,
  parameter int REM_W  = 12,
  parameter int DEPTH  = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              inc_i,
  input  logic [SEL_W-1:0]  load_sel_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [REM_W-1:0]  load_cnt_i,
  output logic [SEL_W-1:0]  sel_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [REM_W-1:0]  remaining_o
);

  logic [SEL_W-1:0]  sel_q,  sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [REM_W-1:0]  rem_q,  rem_d;

  always_comb begin
    sel_d  = sel_q;
    addr_d = addr_q;
    rem_d  = rem_q;
    if (load_i) begin
      sel_d  = load_sel_i;
      addr_d = load_addr_i;
      rem_d  = load_cnt_i;
    end else if (inc_i) begin
      rem_d = rem_q - REM_W'(1);
      // Last entry of an SRAM: continue at entry 0 of the next SRAM.
      if (addr_q == ADDR_W'(DEPTH - 1)) begin
        addr_d = '0;
        sel_d  = sel_q + SEL_W'(1);
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q  <= '0;
      addr_q <= '0;
      rem_q  <= '0;
    end else begin
      sel_q  <= sel_d;
      addr_q <= addr_d;
      rem_q  <= rem_d;
    end
  end

  assign sel_o       = sel_q;
  assign addr_o      = addr_q;
  assign remaining_o = rem_q;

endmodule

// File: rtl/bv_cfg_loader.sv
// bv_cfg_loader: turns a valid/ready stream (header beat + N data beats) into
// per-cycle write strobes for the BV SRAM bank.
// Optional build macro: BV_CFG_PARITY_EN enables even-parity checking of the
// header word (error code 3).
//   clk, rst     clock, asynchronous active-high reset
//   cfg_valid    beat valid          cfg_ready   loader accepts a beat
//   cfg_data     header/data word    cfg_last    final beat of a burst
//   sram_sel     target SRAM         config_en   one-cycle write strobe
//   config_addr  write address       config_i    write data
//   busy         state is not IDLE   done        burst finished cleanly
//   err          sticky error code   err_clr     clears err
module bv_cfg_loader
  import bv_cfg_pkg::*;
#(
  parameter int SRAM_NUM   = DEF_SRAM_NUM,
  parameter int DATA_DEPTH = DEF_DATA_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [DATA_WIDTH-1:0]       cfg_data,
  input  logic                        cfg_last,
  output logic [$clog2(SRAM_NUM)-1:0] sram_sel,
  output logic                        config_en,
  output logic [ADDR_WIDTH-1:0]       config_addr,
  output logic [DATA_WIDTH-1:0]       config_i,
  output logic                        busy,
  output logic                        done,
  output logic [1:0]                  err,
  input  logic                        err_clr
);

  localparam int SEL_W = $clog2(SRAM_NUM);
  localparam int REM_W = CNT_WIDTH + 1;   // count ranges 1..2^CNT_WIDTH
  localparam int POS_W = CNT_WIDTH + 2;   // linear end position incl. overshoot

  state_e                  state_q, state_d;
  logic [1:0]              err_q, err_d;
  logic                    ready_q;
  logic                    en_q, en_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;

  logic                    beat;
  logic                    gen_load, gen_inc;
  logic [SEL_W-1:0]        gen_sel;
  logic [ADDR_WIDTH-1:0]   gen_addr;
  logic [REM_W-1:0]        gen_rem;

  logic [SEL_W-1:0]        hdr_sram;
  logic [ADDR_WIDTH-1:0]   hdr_addr;
  logic [REM_W-1:0]        hdr_cnt;
  logic [POS_W-1:0]        end_pos;
  logic                    hdr_bad;
  logic                    par_bad;

  assign beat = cfg_valid & ready_q;

  assign hdr_sram = cfg_data[HDR_SRAM_MSB:HDR_SRAM_LSB];
  assign hdr_addr = cfg_data[HDR_ADDR_MSB:HDR_ADDR_LSB];
  assign hdr_cnt  = {1'b0, cfg_data[HDR_CNT_MSB:HDR_CNT_LSB]} + REM_W'(1);

  // One past the last linear entry the burst would touch; must not exceed
  // the total table size.
  assign end_pos = POS_W'(hdr_sram) * POS_W'(DATA_DEPTH) + POS_W'(hdr_addr)
                 + POS_W'(hdr_cnt);
  assign hdr_bad = (hdr_addr >= ADDR_WIDTH'(DATA_DEPTH)) ||
                   (end_pos > POS_W'(SRAM_NUM * DATA_DEPTH));

`ifdef BV_CFG_PARITY_EN
  assign par_bad = ^cfg_data;
`else
  assign par_bad = 1'b0;
`endif

  bv_cfg_addr_gen #(
    .SEL_W  (SEL_W),
    .ADDR_W (ADDR_WIDTH),
    .REM_W  (REM_W),
    .DEPTH  (DATA_DEPTH)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .load_i      (gen_load),
    .inc_i       (gen_inc),
    .load_sel_i  (hdr_sram),
    .load_addr_i (hdr_addr),
    .load_cnt_i  (hdr_cnt),
    .sel_o       (gen_sel),
    .addr_o      (gen_addr),
    .remaining_o (gen_rem)
  );

  always_comb begin
    state_d  = state_q;
    // A new error below overrides a same-cycle clear.
    err_d    = err_clr ? ERR_NONE : err_q;
    gen_load = 1'b0;
    gen_inc  = 1'b0;
    en_d     = 1'b0;
    sel_d    = sel_q;
    addr_d   = addr_q;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        if (beat) begin
          if (par_bad) begin
            err_d = ERR_PAR;
            if (!cfg_last) state_d = DRAIN;
          end else if (hdr_bad) begin
            err_d = ERR_HDR;
            if (!cfg_last) state_d = DRAIN;
          end else if (cfg_last) begin
            err_d = ERR_LEN;
          end else begin
            gen_load = 1'b1;
            state_d  = WRITE;
          end
        end
      end
      WRITE: begin
        if (beat) begin
          en_d    = 1'b1;
          sel_d   = gen_sel;
          addr_d  = gen_addr;
          data_d  = cfg_data;
          gen_inc = 1'b1;
          if (gen_rem == REM_W'(1)) begin
            if (cfg_last) begin
              state_d = DONE;
            end else begin
              err_d   = ERR_LEN;
              state_d = DRAIN;
            end
          end else if (cfg_last) begin
            err_d   = ERR_LEN;
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (beat && cfg_last) state_d = IDLE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= ERR_NONE;
      ready_q <= 1'b0;
      en_q    <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      // Registered so the handshake output is also 0 while in reset.
      ready_q <= (state_d != DONE);
      en_q    <= en_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign cfg_ready   = ready_q;
  assign config_en   = en_q;
  assign sram_sel    = sel_q;
  assign config_addr = addr_q;
  assign config_i    = data_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign err         = err_q;

endmodule

// File: tb/tb_bv_cfg_loader.sv
module tb_bv_cfg_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_data;
  logic        cfg_last;
  logic [4:0]  sram_sel;
  logic        config_en;
  logic [5:0]  config_addr;
  logic [31:0] config_i;
  logic        busy;
  logic        done;
  logic [1:0]  err;
  logic        err_clr;

  bv_cfg_loader dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_data    (cfg_data),
    .cfg_last    (cfg_last),
    .sram_sel    (sram_sel),
    .config_en   (config_en),
    .config_addr (config_addr),
    .config_i    (config_i),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          sel;
    int          addr;
    logic [31:0] data;
  } wr_t;
  wr_t wq[$];
  int  done_cnt = 0;
  int  ready_in_done = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (config_en) wq.push_back('{int'(sram_sel), int'(config_addr), config_i});
      if (done) done_cnt++;
      if (done && cfg_ready) ready_in_done++;
    end
  end

  typedef struct {
    int sram;
    int addr;
    int count;
    int nbeats;
    int err_exp;
    int nwr_exp;
    int done_exp;
    int first_sel;
    int first_addr;
    int last_sel;
    int last_addr;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs[NVEC];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_hdr(int sram, int addr, int count);
    logic [31:0] h;
    h        = 32'h0;
    h[4:0]   = sram[4:0];
    h[10:5]  = addr[5:0];
    h[21:11] = 11'(count - 1);
    h[30:22] = 9'h1A5;
`ifdef BV_CFG_PARITY_EN
    h[31] = ^h[30:0];
`else
    h[31] = ~(^h[30:0]);
`endif
    return h;
  endfunction

  task automatic send(logic [31:0] d, logic l);
    int w;
    cfg_data  = d;
    cfg_last  = l;
    cfg_valid = 1'b1;
    w = 0;
    while (1) begin
      @(negedge clk);
      if (cfg_ready) break;
      w++;
      if (w > 20) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: got ready=0 expected ready=1 within 20 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic idle(int n);
    cfg_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    chk("err_clr", 64'(err), 64'd0);
  endtask

  task automatic run_burst(int sram, int addr, int count, int nbeats,
                           logic [31:0] base, bit gaps);
    wq.delete();
    done_cnt = 0;
    send(mk_hdr(sram, addr, count), nbeats == 0);
    for (int i = 0; i < nbeats; i++) begin
      if (gaps) idle($urandom_range(0, 2));
      send(base + 32'(i), i == nbeats - 1);
    end
    idle(3);
  endtask

  task automatic check_order(string name, logic [31:0] base, int nexp);
    int bad;
    bad = 0;
    for (int i = 0; i < wq.size() && i < nexp; i++)
      if (wq[i].data !== base + 32'(i)) bad++;
    chk({name, "_data_order_bad"}, 64'(bad), 64'd0);
  endtask

  initial begin
    logic [31:0] base;
    logic [31:0] h;

    //           sram addr count nb  err nwr done fs fa  ls la
    vecs[0] = '{0,  0,   3,    3,  0,  3,  1,  0, 0,  0, 2};   // basic
    vecs[1] = '{4,  46,  4,    4,  0,  4,  1,  4, 46, 5, 1};   // rollover
    vecs[2] = '{0,  48,  1,    2,  1,  0,  0,  0, 0,  0, 0};   // addr out of range, drained
    vecs[3] = '{2,  10,  5,    3,  2,  3,  0,  2, 10, 2, 12};  // short burst
    vecs[4] = '{7,  0,   2,    4,  2,  2,  0,  7, 0,  7, 1};   // long burst
    vecs[5] = '{31, 47,  2,    2,  1,  0,  0,  0, 0,  0, 0};   // table overflow
    vecs[6] = '{31, 47,  1,    1,  0,  1,  1,  31, 47, 31, 47}; // last entry
    vecs[7] = '{0,  0,   1,    0,  2,  0,  0,  0, 0,  0, 0};   // good header with last
    vecs[8] = '{0,  50,  1,    0,  1,  0,  0,  0, 0,  0, 0};   // bad header with last
    vecs[9] = '{0,  0,   1536, 1536, 0, 1536, 1, 0, 0, 31, 47}; // whole table

    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_data = '0;
    cfg_last = 1'b0;
    err_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_config_en", 64'(config_en), 64'd0);
    chk("rst_outputs", {busy, done, err, cfg_ready, sram_sel, config_addr, config_i},
        64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 64'(cfg_ready), 64'd1);

    for (int v = 0; v < NVEC; v++) begin
      base = 32'hC000_0000 + (32'(v) << 16);
      run_burst(vecs[v].sram, vecs[v].addr, vecs[v].count, vecs[v].nbeats, base, 1'b0);
      $display("[TB] vector %0d: sram=%0d addr=%0d count=%0d beats=%0d -> writes=%0d err=%0d done=%0d",
               v, vecs[v].sram, vecs[v].addr, vecs[v].count, vecs[v].nbeats,
               wq.size(), err, done_cnt);
      chk($sformatf("v%0d_nwr", v), 64'(wq.size()), 64'(vecs[v].nwr_exp));
      chk($sformatf("v%0d_err", v), 64'(err), 64'(vecs[v].err_exp));
      chk($sformatf("v%0d_done", v), 64'(done_cnt), 64'(vecs[v].done_exp));
      chk($sformatf("v%0d_busy", v), 64'(busy), 64'd0);
      if (wq.size() > 0 && vecs[v].nwr_exp > 0) begin
        chk($sformatf("v%0d_first", v), {32'(wq[0].sel), 32'(wq[0].addr)},
            {32'(vecs[v].first_sel), 32'(vecs[v].first_addr)});
        chk($sformatf("v%0d_last", v), {32'(wq[$].sel), 32'(wq[$].addr)},
            {32'(vecs[v].last_sel), 32'(vecs[v].last_addr)});
        check_order($sformatf("v%0d", v), base, vecs[v].nwr_exp);
      end
      clr_err();
    end
    chk("ready_low_in_done", 64'(ready_in_done), 64'd0);

    // Latency and done timing, beat by beat.
    wq.delete();
    send(mk_hdr(1, 20, 2), 1'b0);
    chk("lat_no_write_for_header", 64'(config_en), 64'd0);
    send(32'h1111_AAAA, 1'b0);
    chk("lat_w0", {31'd0, config_en, 8'(sram_sel), 8'(config_addr), config_i},
        {31'd0, 1'b1, 8'd1, 8'd20, 32'h1111_AAAA});
    send(32'h2222_BBBB, 1'b1);
    chk("lat_w1", {30'd0, config_en, done, 8'(sram_sel), 8'(config_addr), config_i},
        {30'd0, 1'b1, 1'b1, 8'd1, 8'd21, 32'h2222_BBBB});
    chk("lat_ready_in_done", 64'(cfg_ready), 64'd0);
    idle(1);
    chk("lat_after_done", {config_en, done, busy, cfg_ready}, 64'b0001);
    $display("[TB] latency sequence: 2 writes checked");

    // Sticky error, then clear colliding with a new error.
    run_burst(0, 0, 1, 0, 32'h0, 1'b0);
    idle(4);
    chk("err_sticky", 64'(err), 64'd2);
    err_clr = 1'b1;
    send(mk_hdr(0, 48, 1), 1'b1);
    err_clr = 1'b0;
    chk("err_clr_collision", 64'(err), 64'd1);
    $display("[TB] err_clr collision: err=%0d", err);
    clr_err();

    // Gappy 96-word burst: each word once, in order.
    base = 32'h5A00_0000;
    run_burst(3, 5, 96, 96, base, 1'b1);
    $display("[TB] gappy burst: writes=%0d err=%0d done=%0d", wq.size(), err, done_cnt);
    chk("gap_nwr", 64'(wq.size()), 64'd96);
    chk("gap_err", 64'(err), 64'd0);
    chk("gap_done", 64'(done_cnt), 64'd1);
    if (wq.size() == 96) begin
      chk("gap_first", {32'(wq[0].sel), 32'(wq[0].addr)}, {32'd3, 32'd5});
      chk("gap_last", {32'(wq[95].sel), 32'(wq[95].addr)}, {32'd5, 32'd4});
      check_order("gap", base, 96);
    end

    // Reset in the middle of a burst.
    send(mk_hdr(0, 0, 10), 1'b0);
    send(32'h0, 1'b0);
    send(32'h1, 1'b0);
    chk("mid_busy_before_rst", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_outputs", {config_en, busy, done, cfg_ready, err}, 64'd0);
    idle(2);
    rst = 1'b0;
    idle(1);
    chk("mid_rst_ready", 64'(cfg_ready), 64'd1);
    $display("[TB] mid-burst reset: busy=%0d config_en=%0d", busy, config_en);

`ifdef BV_CFG_PARITY_EN
    wq.delete();
    h = mk_hdr(0, 0, 2);
    h[31] = ~h[31];
    send(h, 1'b0);
    send(32'h7, 1'b0);
    send(32'h8, 1'b1);
    idle(2);
    $display("[TB] parity error header: writes=%0d err=%0d", wq.size(), err);
    chk("par_err", 64'(err), 64'd3);
    chk("par_nwr", 64'(wq.size()), 64'd0);
    chk("par_busy", 64'(busy), 64'd0);
    clr_err();
`else
    h = 32'h0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
